// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t  : one prefetch queue entry {pc, instr}
//   ifetch_state_t : fetch FSM state (BOOT, FETCH, FULL)
//   INSTR_BYTES    : fetch address increment per instruction
package ifetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue holding fetch_entry_t, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write an entry (ignored when full or flushing)
//   pop, rdata     : head entry / remove head (ignored when empty or flushing)
//   flush          : empty the queue; wins over push and pop
//   full, empty    : occupancy flags
//   count          : number of valid entries (0..DEPTH)
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential reads to instruction memory,
// buffers responses in a prefetch queue and presents them downstream.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (misaligned redirect sets
// sticky FETCH_ERR and stops fetching; otherwise REDIRECT_PC[1:0] is ignored).
// Ports:
//   CLK, RESET_N              : clock, asynchronous active-low reset
//   REDIRECT, REDIRECT_PC     : flush and restart fetch at REDIRECT_PC
//   MEM_REQ, MEM_ADDR         : memory read request / address
//   MEM_GNT                   : request accepted this cycle
//   MEM_RVALID, MEM_RDATA     : in-order read response
//   IR_VALID, IR, IR_PC       : queue head instruction and its address
//   IR_READY                  : downstream consumes the head
//   FETCH_ERR                 : sticky misaligned-redirect flag
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        IR_VALID,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  input  logic        IR_READY,
  output logic        FETCH_ERR
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = CW + 1;

  ifetch_state_t state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outst;
  logic [CW-1:0] discard;
  logic          err;
  logic [31:0]   redir_pc;

  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;
  fetch_entry_t  q_wdata;
  fetch_entry_t  q_head;

  logic [TW-1:0] total;
  logic [TW-1:0] total_next;
  logic          grant;
  logic          rsp_keep;
  logic          rsp_drop;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign redir_pc = REDIRECT_PC;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      err <= 1'b0;
    else if (REDIRECT) err <= |REDIRECT_PC[1:0];
  end
`else
  logic [1:0] unused_redir_lo;
  assign unused_redir_lo = REDIRECT_PC[1:0];
  assign redir_pc        = {REDIRECT_PC[31:2], 2'b00};
  assign err             = 1'b0;
`endif

  always_comb begin
    // Throttle counts queued entries, live requests and responses still
    // owed to a flushed stream.
    total      = TW'(q_count) + TW'(outst) + TW'(discard);
    MEM_REQ    = (state == FETCH) && !REDIRECT && !err && (total < TW'(DEPTH));
    grant      = MEM_REQ && MEM_GNT;
    rsp_drop   = MEM_RVALID && (discard != '0);
    rsp_keep   = MEM_RVALID && (discard == '0) && (outst != '0);
    q_push     = rsp_keep && !REDIRECT && !q_full;
    q_pop      = IR_VALID && IR_READY && !REDIRECT;
    total_next = total + TW'(grant) - TW'(rsp_drop) - TW'(q_pop);
    // Live requests are consecutive, so the oldest one sits outst
    // instructions behind the fetch PC; no per-request PC storage needed.
    q_wdata.pc    = fetch_pc - 32'(outst) * 32'(INSTR_BYTES);
    q_wdata.instr = MEM_RDATA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= BOOT;
      fetch_pc <= RESET_VEC;
      outst    <= '0;
      discard  <= '0;
    end else if (REDIRECT) begin
      state    <= FETCH;
      fetch_pc <= redir_pc;
      outst    <= '0;
      // A response arriving on the redirect cycle belongs to the old stream
      // and is consumed here rather than counted as a future discard.
      discard  <= discard + outst - CW'(MEM_RVALID && ((discard | outst) != '0));
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      outst   <= outst + CW'(grant) - CW'(rsp_keep);
      discard <= discard - CW'(rsp_drop);
      case (state)
        BOOT:        state <= FETCH;
        FETCH, FULL: state <= (total_next == TW'(DEPTH)) ? FULL : FETCH;
        default:     state <= BOOT;
      endcase
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (q_push),
    .pop   (q_pop),
    .flush (REDIRECT),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign MEM_ADDR  = fetch_pc;
  assign IR_VALID  = !q_empty;
  assign IR        = q_empty ? '0 : q_head.instr;
  assign IR_PC     = q_empty ? '0 : q_head.pc;
  assign FETCH_ERR = err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit (DEPTH=4, RESET_VEC=0x100).
// Memory/stimulus driver, scoreboard monitor and directed/random sequences.
// Build with +define+IFETCH_MISALIGN_CHK_EN to exercise the misalign check.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        IR_VALID;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_READY = 1'b0;
  logic        FETCH_ERR;

  ifetch_unit #(
    .DEPTH     (DEPTH),
    .RESET_VEC (RESET_VEC)
  ) u_dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_GNT     (MEM_GNT),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RDATA   (MEM_RDATA),
    .IR_VALID    (IR_VALID),
    .IR          (IR),
    .IR_PC       (IR_PC),
    .IR_READY    (IR_READY),
    .FETCH_ERR   (FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int unsigned cyc;
  } mreq_t;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  cyc = 0;
  int unsigned  pop_count = 0;

  mreq_t        mem_q[$];      // requests accepted by memory, not yet answered
  fetch_entry_t exp_q[$];      // expected downstream stream (current fetch stream)
  logic [31:0]  grant_log[$];
  logic [31:0]  pop_log[$];
  logic [31:0]  exp_fetch = RESET_VEC;

  // Stimulus controls
  bit          gnt_rand = 0;
  int unsigned gnt_pct = 100;
  int unsigned gnt_wait = 0;
  int          gnt_cap = 99;
  int unsigned rsp_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned rand_redir_pm = 0;
  bit          redir_req = 0;
  logic [31:0] redir_target = '0;
  bit          pop_once = 0;
  int unsigned req_age = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef IFETCH_MISALIGN_CHK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver + memory model: inputs change at negedge, grant decided after
  // MEM_REQ settles, handshakes recorded at negedge+2.
  always begin
    logic        g;
    logic [31:0] tgt;
    @(negedge CLK);
    cyc++;
    if (!RESET_N) begin
      REDIRECT   = 1'b0;
      IR_READY   = 1'b0;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = '0;
      MEM_GNT    = 1'b0;
      mem_q.delete();
      exp_q.delete();
      exp_fetch  = RESET_VEC;
      req_age    = 0;
    end else begin
      if (redir_req) begin
        REDIRECT    = 1'b1;
        REDIRECT_PC = redir_target;
        redir_req   = 0;
      end else if ($urandom_range(999) < rand_redir_pm) begin
        tgt         = $urandom() & 32'hFFFF_FFFC;
        REDIRECT    = 1'b1;
        REDIRECT_PC = tgt;
      end else begin
        REDIRECT    = 1'b0;
        REDIRECT_PC = $urandom();
      end
      IR_READY = pop_once || ($urandom_range(99) < rdy_pct);
      pop_once = 0;
      if (mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = memfn(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        MEM_RVALID = 1'b0;
        MEM_RDATA  = $urandom();
      end
      #1;
      if (MEM_REQ) begin
        if (gnt_rand) g = ($urandom_range(99) < gnt_pct);
        else          g = (req_age >= gnt_wait);
        g = g && (mem_q.size() < gnt_cap);
        req_age = g ? 0 : req_age + 1;
      end else begin
        g = 1'b0;
        req_age = 0;
      end
      MEM_GNT = g;
      #1;
      if (REDIRECT) begin
        chk("req_on_redirect", MEM_REQ, 1'b0);
        exp_q.delete();
        exp_fetch = model_target(REDIRECT_PC);
      end else if (MEM_REQ && MEM_GNT) begin
        chk("mem_addr", MEM_ADDR, exp_fetch);
        grant_log.push_back(MEM_ADDR);
        mem_q.push_back('{addr: MEM_ADDR, cyc: cyc});
        exp_q.push_back('{pc: exp_fetch, instr: memfn(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
        chk("throttle", exp_q.size() <= DEPTH, 1'b1);
      end
    end
  end

  // Scoreboard monitor: every consumed instruction must match the model stream.
  always begin
    fetch_entry_t e;
    @(negedge CLK);
    #3;
    if (RESET_N && !REDIRECT && IR_VALID && IR_READY) begin
      pop_log.push_back(IR_PC);
      pop_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ir_unexpected actual_pc=%h required=none", IR_PC);
      end else begin
        e = exp_q.pop_front();
        chk("ir_pc", IR_PC, e.pc);
        chk("ir", IR, e.instr);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #4;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redir_target = t;
    redir_req    = 1;
    step();
    grant_log.delete();
    pop_log.delete();
  endtask

  task automatic wait_grants(input int n, input string name);
    for (int i = 0; i < 40 && grant_log.size() < n; i++) step();
    chk(name, grant_log.size() >= n, 1'b1);
  endtask

  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 40 && pop_log.size() < n; i++) step();
    chk(name, pop_log.size() >= n, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_req", MEM_REQ, 1'b0);
    chk("rst_mem_addr", MEM_ADDR, RESET_VEC);
    chk("rst_ir_valid", IR_VALID, 1'b0);
    chk("rst_ir", IR, '0);
    chk("rst_ir_pc", IR_PC, '0);
    chk("rst_fetch_err", FETCH_ERR, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and sequential fetch from RESET_VEC
    repeat (3) step();
    chk_reset_outputs();
    grant_log.delete();
    pop_log.delete();
    RESET_N = 1'b1;
    wait_grants(3, "s1_grants");
    chk("s1_addr0", grant_log[0], 32'h100);
    chk("s1_addr1", grant_log[1], 32'h104);
    chk("s1_addr2", grant_log[2], 32'h108);
    wait_pops(3, "s1_pops");
    chk("s1_pc0", pop_log[0], 32'h100);
    chk("s1_pc1", pop_log[1], 32'h104);
    chk("s1_pc2", pop_log[2], 32'h108);

    // Throttle with a stalled consumer
    rdy_pct = 0;
    do_redirect(32'h1000);
    repeat (20) step();
    chk("s2_grants", grant_log.size(), 32'd4);
    chk("s2_req_off", MEM_REQ, 1'b0);
    chk("s2_full_state", u_dut.state, FULL);
    pop_once = 1;
    repeat (10) step();
    chk("s2_one_more", grant_log.size(), 32'd5);
    chk("s2_pop_pc", pop_log[0], 32'h1000);
    chk("s2_full_again", u_dut.state, FULL);

    // Grant delayed by three cycles
    rdy_pct = 100;
    do_redirect(32'h100);
    wait_grants(1, "s3_first");
    gnt_wait = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_req_held", MEM_REQ, 1'b1);
      chk("s3_addr_held", MEM_ADDR, 32'h104);
      chk("s3_no_grant", grant_log.size(), 32'd1);
    end
    step();
    chk("s3_granted", grant_log.size(), 32'd2);
    chk("s3_grant_addr", grant_log[1], 32'h104);
    step();
    chk("s3_pc_adv", MEM_ADDR, 32'h108);
    gnt_wait = 0;

    // Redirect with two responses outstanding
    rsp_pct = 0;
    gnt_cap = 2;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
    chk("s4_outstanding", mem_q.size(), 32'd2);
    do_redirect(32'h200);
    rsp_pct = 100;
    gnt_cap = 99;
    step();
    chk("s4_ir_invalid", IR_VALID, 1'b0);
    wait_pops(2, "s4_pops");
    chk("s4_first_pc", pop_log[0], 32'h200);
    chk("s4_second_pc", pop_log[1], 32'h204);

    // Address wrap
    do_redirect(32'hFFFF_FFFC);
    wait_grants(2, "s5_grants");
    chk("s5_addr_top", grant_log[0], 32'hFFFF_FFFC);
    chk("s5_addr_wrap", grant_log[1], 32'h0);
    wait_pops(2, "s5_pops");
    chk("s5_pc_wrap", pop_log[1], 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
    do_redirect(32'h202);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s6_err_set", FETCH_ERR, 1'b1);
      chk("s6_req_off", MEM_REQ, 1'b0);
    end
    chk("s6_no_grants", grant_log.size(), 32'd0);
    do_redirect(32'h300);
    wait_grants(1, "s6_resume");
    chk("s6_resume_addr", grant_log[0], 32'h300);
    chk("s6_err_clear", FETCH_ERR, 1'b0);
`else
    do_redirect(32'h30A);
    wait_grants(1, "s6_aligned");
    chk("s6_forced_align", grant_log[0], 32'h308);
    chk("s6_err_tied", FETCH_ERR, 1'b0);
`endif

    // Randomized traffic
    gnt_rand      = 1;
    gnt_pct       = 60;
    rsp_pct       = 60;
    rdy_pct       = 70;
    rand_redir_pm = 20;
    pop_count     = 0;
    repeat (3000) step();
    chk("rand_progress", pop_count > 200, 1'b1);

    // Reset in the middle of traffic abandons everything in flight
    RESET_N = 1'b0;
    gnt_rand      = 0;
    rsp_pct       = 100;
    rdy_pct       = 100;
    rand_redir_pm = 0;
    repeat (2) step();
    chk_reset_outputs();
    grant_log.delete();
    pop_log.delete();
    RESET_N = 1'b1;
    wait_grants(1, "s7_grants");
    chk("s7_restart_addr", grant_log[0], RESET_VEC);
    wait_pops(1, "s7_pops");
    chk("s7_restart_pc", pop_log[0], RESET_VEC);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
